// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, parity modes and bit-period helper.
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } state_t;

    localparam int PAR_NONE = 0;
    localparam int PAR_ODD  = 1;
    localparam int PAR_EVEN = 2;

    // Clocks per line bit (integer division); also used for receiver oversampling.
    function automatic int bit_period(input int clk_freq, input int baud_rate);
        return clk_freq / baud_rate;
    endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Free-running bit-period counter; bit_tick is high on the last clock of each period.
module uart_baud_gen
    import uart_pkg::*;
#(
    parameter int BIT_CNT_TH = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic restart,
    output logic bit_tick
);

    localparam int CW = $clog2(BIT_CNT_TH);
    localparam logic [CW-1:0] LAST = CW'(BIT_CNT_TH - 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
        end else if (restart || bit_tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

    assign bit_tick = (cnt == LAST);

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: one-entry holding register feeding a start/data/parity/stop framing FSM.
module uart_tx
    import uart_pkg::*;
#(
    parameter int CLK_FREQ   = 100_000_000,
    parameter int BAUD_RATE  = 9600,
    parameter int DATA_WIDTH = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] i_tx_data,
    input  logic                  i_tx_vld,
    output logic                  o_tx_rdy,
    output logic                  o_tx_bit,
    output logic                  o_tx_busy,
    output logic                  o_tx_done
);

    localparam int BIT_CNT_TH = bit_period(CLK_FREQ, BAUD_RATE);
    localparam int BW         = $clog2(DATA_WIDTH);
    localparam logic [BW-1:0] LAST_BIT = BW'(DATA_WIDTH - 1);

    if (BIT_CNT_TH < 2) begin : g_th_check
        $error("uart_tx: CLK_FREQ/BAUD_RATE must be at least 2");
    end
    if (DATA_WIDTH < 5 || DATA_WIDTH > 9) begin : g_dw_check
        $error("uart_tx: DATA_WIDTH must be 5..9");
    end
    if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_sb_check
        $error("uart_tx: STOP_BITS must be 1 or 2");
    end

    state_t                state, state_nxt;
    logic [DATA_WIDTH-1:0] hold;
    logic                  hold_full;
    logic [DATA_WIDTH-1:0] sr, sr_nxt;
    logic [BW-1:0]         bit_cnt, bit_cnt_nxt;
    logic                  stop_cnt, stop_cnt_nxt;
    logic                  par_bit, par_nxt;
    logic                  tx_bit_nxt;
    logic                  done_nxt;
    logic                  load;
    logic                  bit_tick;

    assign o_tx_rdy  = !hold_full;
    assign o_tx_busy = (state != ST_IDLE);

    uart_baud_gen #(
        .BIT_CNT_TH(BIT_CNT_TH)
    ) u_baud (
        .clk     (clk),
        .rst     (rst),
        .restart (load),
        .bit_tick(bit_tick)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hold      <= '0;
            hold_full <= 1'b0;
        end else if (i_tx_vld && !hold_full) begin
            hold      <= i_tx_data;
            hold_full <= 1'b1;
        end else if (load) begin
            hold_full <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= ST_IDLE;
            sr        <= '0;
            bit_cnt   <= '0;
            stop_cnt  <= 1'b0;
            par_bit   <= 1'b0;
            o_tx_bit  <= 1'b1;
            o_tx_done <= 1'b0;
        end else begin
            state     <= state_nxt;
            sr        <= sr_nxt;
            bit_cnt   <= bit_cnt_nxt;
            stop_cnt  <= stop_cnt_nxt;
            par_bit   <= par_nxt;
            o_tx_bit  <= tx_bit_nxt;
            o_tx_done <= done_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        sr_nxt       = sr;
        bit_cnt_nxt  = bit_cnt;
        stop_cnt_nxt = stop_cnt;
        par_nxt      = par_bit;
        tx_bit_nxt   = o_tx_bit;
        done_nxt     = 1'b0;
        load         = 1'b0;

        case (state)
            ST_IDLE: begin
                tx_bit_nxt = 1'b1;
                load       = hold_full;
            end
            ST_START: begin
                if (bit_tick) begin
                    state_nxt   = ST_DATA;
                    tx_bit_nxt  = sr[0];
                    sr_nxt      = sr >> 1;
                    bit_cnt_nxt = '0;
                end
            end
            ST_DATA: begin
                if (bit_tick) begin
                    if (bit_cnt == LAST_BIT) begin
                        if (PARITY != PAR_NONE) begin
                            state_nxt  = ST_PARITY;
                            tx_bit_nxt = par_bit;
                        end else begin
                            state_nxt    = ST_STOP;
                            tx_bit_nxt   = 1'b1;
                            stop_cnt_nxt = 1'b0;
                        end
                    end else begin
                        tx_bit_nxt  = sr[0];
                        sr_nxt      = sr >> 1;
                        bit_cnt_nxt = bit_cnt + BW'(1);
                    end
                end
            end
            ST_PARITY: begin
                if (bit_tick) begin
                    state_nxt    = ST_STOP;
                    tx_bit_nxt   = 1'b1;
                    stop_cnt_nxt = 1'b0;
                end
            end
            ST_STOP: begin
                if (bit_tick) begin
                    if (stop_cnt == 1'(STOP_BITS - 1)) begin
                        done_nxt = 1'b1;
                        if (hold_full) begin
                            load = 1'b1;
                        end else begin
                            state_nxt  = ST_IDLE;
                            tx_bit_nxt = 1'b1;
                        end
                    end else begin
                        stop_cnt_nxt = 1'b1;
                    end
                end
            end
            default: begin
                state_nxt  = ST_IDLE;
                tx_bit_nxt = 1'b1;
            end
        endcase

        // Loading from IDLE and the back-to-back reload out of STOP share one path.
        if (load) begin
            state_nxt  = ST_START;
            sr_nxt     = hold;
            par_nxt    = (^hold) ^ (PARITY == PAR_ODD);
            tx_bit_nxt = 1'b0;
        end
    end

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx: three parity/stop configurations at 16 clocks per bit.
module tb_uart_tx;

    localparam int CLK_FREQ = 1_600_000;
    localparam int BAUD     = 100_000;
    localparam int T        = 16;

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic [2:0][7:0] tx_data;
    logic [2:0]      tx_vld;
    logic [2:0]      tx_rdy;
    logic [2:0]      tx_bit;
    logic [2:0]      tx_busy;
    logic [2:0]      tx_done;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    // index 0: no parity, 1 stop; 1: even parity, 2 stop; 2: odd parity, 1 stop
    uart_tx #(.CLK_FREQ(CLK_FREQ), .BAUD_RATE(BAUD), .DATA_WIDTH(8), .PARITY(0), .STOP_BITS(1)) dut_none (
        .clk(clk), .rst(rst), .i_tx_data(tx_data[0]), .i_tx_vld(tx_vld[0]),
        .o_tx_rdy(tx_rdy[0]), .o_tx_bit(tx_bit[0]), .o_tx_busy(tx_busy[0]), .o_tx_done(tx_done[0]));
    uart_tx #(.CLK_FREQ(CLK_FREQ), .BAUD_RATE(BAUD), .DATA_WIDTH(8), .PARITY(2), .STOP_BITS(2)) dut_even (
        .clk(clk), .rst(rst), .i_tx_data(tx_data[1]), .i_tx_vld(tx_vld[1]),
        .o_tx_rdy(tx_rdy[1]), .o_tx_bit(tx_bit[1]), .o_tx_busy(tx_busy[1]), .o_tx_done(tx_done[1]));
    uart_tx #(.CLK_FREQ(CLK_FREQ), .BAUD_RATE(BAUD), .DATA_WIDTH(8), .PARITY(1), .STOP_BITS(1)) dut_odd (
        .clk(clk), .rst(rst), .i_tx_data(tx_data[2]), .i_tx_vld(tx_vld[2]),
        .o_tx_rdy(tx_rdy[2]), .o_tx_bit(tx_bit[2]), .o_tx_busy(tx_busy[2]), .o_tx_done(tx_done[2]));

    // bits holds the frame in time order, first line bit in bit 11
    typedef struct packed {
        logic [1:0]  inst;
        logic [7:0]  data;
        logic [11:0] bits;
        logic [3:0]  nbits;
    } vec_t;

    vec_t vecs [8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    task automatic run_frame(input int inst, input logic [7:0] d, input logic [11:0] bits, input int nbits);
        int len;
        len = nbits * T;
        @(negedge clk);
        check($sformatf("rdy_before[%0d]", inst), 32'(tx_rdy[inst]), 1);
        tx_data[inst] = d;
        tx_vld[inst]  = 1'b1;
        @(negedge clk);
        tx_vld[inst]  = 1'b0;
        tx_data[inst] = ~d;
        check($sformatf("latency_bit[%0d]", inst), 32'(tx_bit[inst]), 1);
        check($sformatf("rdy_full[%0d]", inst), 32'(tx_rdy[inst]), 0);
        for (int k = 0; k <= len; k++) begin
            @(negedge clk);
            if (k < len) begin
                check($sformatf("line[%0d] %02h k=%0d", inst, d, k), 32'(tx_bit[inst]), 32'(bits[11 - k / T]));
                check($sformatf("busy[%0d] k=%0d", inst, k), 32'(tx_busy[inst]), 1);
                check($sformatf("done_early[%0d] k=%0d", inst, k), 32'(tx_done[inst]), 0);
            end else begin
                check($sformatf("done_pulse[%0d] %02h", inst, d), 32'(tx_done[inst]), 1);
                check($sformatf("idle_bit[%0d]", inst), 32'(tx_bit[inst]), 1);
            end
        end
        @(negedge clk);
        check($sformatf("done_width[%0d]", inst), 32'(tx_done[inst]), 0);
        check($sformatf("busy_end[%0d]", inst), 32'(tx_busy[inst]), 0);
    endtask

    task automatic reset_mid_frame(input logic [7:0] d, input int at_k, input logic exp_before);
        int ndone;
        int nlow;
        @(negedge clk);
        tx_data[0] = d;
        tx_vld[0]  = 1'b1;
        @(negedge clk);
        tx_vld[0] = 1'b0;
        for (int k = 0; k <= at_k; k++) @(negedge clk);
        check("line_before_reset", 32'(tx_bit[0]), 32'(exp_before));
        #2 rst = 1'b0;
        #1;
        check("async_bit", 32'(tx_bit[0]), 1);
        check("async_busy", 32'(tx_busy[0]), 0);
        check("async_rdy", 32'(tx_rdy[0]), 1);
        check("async_done", 32'(tx_done[0]), 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        ndone = 0;
        nlow  = 0;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (tx_done[0]) ndone++;
            if (!tx_bit[0]) nlow++;
        end
        check("no_done_after_abort", 32'(ndone), 0);
        check("line_idle_after_abort", 32'(nlow), 0);
    endtask

    initial begin
        logic [19:0] b2b_bits;
        logic [7:0]  q [3];
        logic [7:0]  rx_bytes [3];
        logic [7:0]  rx_sr;
        int          first_done, second_done, ndone, idx, nrx, rx_cnt;
        bit          pending, rx_act;

        tx_data = '0;
        tx_vld  = '0;

        vecs[0] = '{2'd0, 8'hA5, 12'b0101001011_00, 4'd10};
        vecs[1] = '{2'd0, 8'h00, 12'b0000000001_00, 4'd10};
        vecs[2] = '{2'd0, 8'hFF, 12'b0111111111_00, 4'd10};
        vecs[3] = '{2'd1, 8'h07, 12'b011100000111,  4'd12};
        vecs[4] = '{2'd1, 8'h3C, 12'b000111100011,  4'd12};
        vecs[5] = '{2'd2, 8'h07, 12'b01110000001_0, 4'd11};
        vecs[6] = '{2'd2, 8'h3C, 12'b00011110011_0, 4'd11};
        vecs[7] = '{2'd1, 8'h80, 12'b000000001111,  4'd12};

        // reset and idle
        repeat (3) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            check($sformatf("rst_bit[%0d]", i), 32'(tx_bit[i]), 1);
            check($sformatf("rst_rdy[%0d]", i), 32'(tx_rdy[i]), 1);
        end
        rst = 1'b1;
        repeat (100) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            check($sformatf("idle_bit[%0d]", i), 32'(tx_bit[i]), 1);
            check($sformatf("idle_rdy[%0d]", i), 32'(tx_rdy[i]), 1);
            check($sformatf("idle_busy[%0d]", i), 32'(tx_busy[i]), 0);
            check($sformatf("idle_done[%0d]", i), 32'(tx_done[i]), 0);
        end

        // single frames across parity / stop configurations
        for (int v = 0; v < 8; v++)
            run_frame(int'(vecs[v].inst), vecs[v].data, vecs[v].bits, int'(vecs[v].nbits));

        // back-to-back: second byte accepted during DATA of the first
        b2b_bits = 20'b0101010101_0001111001;
        first_done  = -1;
        second_done = -1;
        ndone       = 0;
        @(negedge clk);
        tx_data[0] = 8'h55;
        tx_vld[0]  = 1'b1;
        @(negedge clk);
        tx_vld[0] = 1'b0;
        for (int k = 0; k <= 2 * 10 * T; k++) begin
            @(negedge clk);
            if (k < 2 * 10 * T) begin
                check($sformatf("b2b_line k=%0d", k), 32'(tx_bit[0]), 32'(b2b_bits[19 - k / T]));
                check($sformatf("b2b_busy k=%0d", k), 32'(tx_busy[0]), 1);
            end
            if (k >= 41 && k < 160) check($sformatf("b2b_rdy_low k=%0d", k), 32'(tx_rdy[0]), 0);
            if (k == 160) check("b2b_rdy_drained", 32'(tx_rdy[0]), 1);
            if (tx_done[0]) begin
                ndone++;
                if (first_done < 0) first_done = k;
                else second_done = k;
            end
            if (k == 40) begin
                check("b2b_rdy_in_data", 32'(tx_rdy[0]), 1);
                tx_data[0] = 8'h3C;
                tx_vld[0]  = 1'b1;
            end
            if (k == 41) begin
                tx_vld[0]  = 1'b0;
                tx_data[0] = 8'hFF;
            end
        end
        check("b2b_done_count", 32'(ndone), 2);
        check("b2b_done_first", 32'(first_done), 160);
        check("b2b_done_second", 32'(second_done), 320);
        repeat (3) @(negedge clk);

        // backpressure: vld held high across three queued bytes, decoded by a receiver model
        q[0] = 8'h01; q[1] = 8'h02; q[2] = 8'h03;
        idx = 0; nrx = 0; ndone = 0; rx_cnt = 0; rx_sr = '0;
        pending = 1'b0;
        rx_act  = 1'b0;
        for (int cyc = 0; cyc < 1200 && nrx < 3; cyc++) begin
            @(negedge clk);
            if (pending) idx++;
            if (idx < 3) begin
                tx_vld[0]  = 1'b1;
                tx_data[0] = q[idx];
            end else begin
                tx_vld[0] = 1'b0;
            end
            pending = tx_vld[0] && tx_rdy[0];
            if (tx_done[0]) ndone++;
            if (!rx_act) begin
                if (!tx_bit[0]) begin
                    rx_act = 1'b1;
                    rx_cnt = 0;
                end
            end else begin
                rx_cnt++;
                if (rx_cnt >= 24 && rx_cnt <= 136 && (rx_cnt - 8) % 16 == 0)
                    rx_sr[(rx_cnt - 24) / 16] = tx_bit[0];
                if (rx_cnt == 152) begin
                    check($sformatf("rx_stop[%0d]", nrx), 32'(tx_bit[0]), 1);
                    rx_bytes[nrx] = rx_sr;
                    nrx++;
                    rx_act = 1'b0;
                end
            end
        end
        tx_vld[0] = 1'b0;
        check("bp_frames", 32'(nrx), 3);
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (tx_done[0]) ndone++;
        end
        check("bp_done_count", 32'(ndone), 3);
        check("bp_idle_busy", 32'(tx_busy[0]), 0);
        check("bp_idle_rdy", 32'(tx_rdy[0]), 1);
        for (int i = 0; i < 3; i++)
            if (i < nrx) check($sformatf("bp_byte[%0d]", i), 32'(rx_bytes[i]), 32'(q[i]));

        // reset mid-frame: data bit 3 of 0xFF, then during the start bit of 0xA5
        reset_mid_frame(8'hFF, 70, 1'b1);
        reset_mid_frame(8'hA5, 5, 1'b0);
        run_frame(0, 8'hA5, 12'b0101001011_00, 10);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/uart_tx.md
Name: uart_tx

Overview:
- Serial UART transmitter; the transmit-side counterpart of the team's oversampling UART receiver.
- Accepts parallel bytes over a valid/ready handshake into a one-entry holding register.
- Frames each byte as start, DATA_WIDTH data bits LSB-first, optional parity, then 1 or 2 stop bits.
- Drives the FPGA TX pin; supports back-to-back frames with no idle gap.

Parameters:
CLK_FREQ, 100_000_000, system clock frequency in Hz
BAUD_RATE, 9600, line bit rate in bits/s
DATA_WIDTH, 8, data bits per frame (5..9)
PARITY, 0, 0 = none, 1 = odd, 2 = even
STOP_BITS, 1, number of stop bits (1 or 2)

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  asynchronous, active-low reset
i_tx_data  input  DATA_WIDTH  byte to send; sampled only on the handshake edge
i_tx_vld  input  1  i_tx_data is valid
o_tx_rdy  output  1  holding register empty; a transfer occurs on an edge where i_tx_vld && o_tx_rdy
o_tx_bit  output  1  serial line, registered, idle high
o_tx_busy  output  1  FSM is not in IDLE
o_tx_done  output  1  one-cycle pulse after the final stop bit of each frame

Behaviour:
- Bit period: BIT_CNT_TH = CLK_FREQ/BAUD_RATE clocks (integer division; 10416 at defaults).
  - Counter width is $clog2(BIT_CNT_TH).
  - Every line bit holds for exactly BIT_CNT_TH clocks.
- Reset (rst = 0, asynchronous) forces:
  - o_tx_bit = 1, o_tx_rdy = 1, o_tx_busy = 0, o_tx_done = 0;
  - holding register empty, state IDLE, counters 0.
  - Reset mid-frame aborts the frame immediately with no o_tx_done pulse.
- Holding register:
  - Handshake edge: stores i_tx_data, sets hold_full; o_tx_rdy = !hold_full.
  - While hold_full, o_tx_rdy stays 0, including on the edge it drains.
  - A new byte can be accepted on the next cycle.
- FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE: o_tx_bit = 1. If hold_full, load the hold into shift register sr, clear hold_full, go to START, and drive o_tx_bit = 0 on the same edge.
    - Latency: handshake edge E0 -> hold_full after E0 -> start bit begins after E1.
  - START: after BIT_CNT_TH clocks go to DATA; o_tx_bit = sr[0].
  - DATA: each bit period, shift sr right and increment bit_cnt.
    - After DATA_WIDTH bits: go to PARITY if PARITY != 0, else STOP.
  - PARITY: o_tx_bit = XOR of the loaded byte, inverted for odd parity. Computed at load time and stored.
  - STOP: o_tx_bit = 1 for STOP_BITS * BIT_CNT_TH clocks.
    - At the end: pulse o_tx_done for one cycle.
    - If hold_full: load and enter START on the same edge (back-to-back, no idle bit). Otherwise go to IDLE.
- o_tx_busy = 1 in every state except IDLE, including during the back-to-back transition.
- i_tx_data changes after the handshake have no effect on the frame in flight.
- i_tx_vld while o_tx_rdy = 0: ignored, no side effects.
- Degenerate case: BIT_CNT_TH < 2 is unsupported; flag it with an elaboration-time check.

Decomposition:
- Shared package uart_pkg holds:
  - FSM state encoding (IDLE/START/DATA/PARITY/STOP);
  - parity mode constants (PAR_NONE, PAR_ODD, PAR_EVEN);
  - a function computing the bit-period threshold from CLK_FREQ/BAUD_RATE. The receiver reuses this function for its oversampling threshold.
- One natural sub-module: uart_baud_gen.
  - Free-running counter with sync restart, emits a one-cycle bit_tick every BIT_CNT_TH clocks.
  - Restarted on frame load so the start bit has full width.
- The holding register and FSM stay in uart_tx.

Test Plan:
1. Reset and idle. Params: CLK_FREQ = 1_600_000, BAUD_RATE = 100_000 (16 clks/bit). Apply reset, release, wait 100 clocks -> o_tx_bit = 1, o_tx_rdy = 1, o_tx_busy = 0, o_tx_done = 0.
2. Single byte 0xA5, PARITY = 0. -> Start bit low begins 2 clocks after the handshake. Line reads 0,1,0,1,0,0,1,0,1,1, each 16 clocks. o_tx_done pulses once at clock 160 of the frame.
3. Parity. 0x07 with PARITY = 2 -> parity bit 1. 0x07 with PARITY = 1 -> parity bit 0. Frame is 11 bits; with STOP_BITS = 2, stop is high for 32 clocks.
4. Back-to-back. Send 0x55, then 0x3C accepted while the first frame is in DATA -> o_tx_rdy low until the hold drains. Second start bit immediately follows the first stop bit (no idle clocks). Two o_tx_done pulses 160 clocks apart.
5. Backpressure. Hold i_tx_vld = 1 with three bytes queued 0x01, 0x02, 0x03 -> exactly three frames, in order. No byte is dropped or duplicated, and the receiver model decodes 0x01, 0x02, 0x03.
6. Reset mid-frame. Assert rst during data bit 3 of 0xFF -> o_tx_bit = 1 asynchronously (before the next clock edge), no o_tx_done, and the next frame after release is correct.
